// File: rtl/demux12_pkg.sv
// Shared types and constants for the demux12_stream slice.
// Occupancy encoding of the skid buffer and the destination codes carried with each beat.
package demux12_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } occ_t;

    localparam logic DEST_A = 1'b0;
    localparam logic DEST_B = 1'b1;

endpackage

// File: rtl/demux12_skid.sv
// Two-entry skid buffer with valid/ready on both sides.
// in_ready and out_valid come straight from flops, so out_ready never reaches in_ready.
//
// state | meaning
// EMPTY | nothing stored, out_valid=0, in_ready=1
// HALF  | main entry valid, out_valid=1, in_ready=1
// FULL  | main and skid valid, out_valid=1, in_ready=0
module demux12_skid
    import demux12_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    occ_t         state;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         accept;
    logic         drain;

    assign accept   = in_valid & in_ready;
    assign drain    = out_valid & out_ready;
    assign out_data = main_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q    <= in_data;
                        out_valid <= 1'b1;
                        state     <= HALF;
                    end
                end
                HALF: begin
                    if (accept && drain) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        skid_q   <= in_data;
                        in_ready <= 1'b0;
                        state    <= FULL;
                    end else if (drain) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so the only event is the head leaving
                    if (drain) begin
                        main_q   <= skid_q;
                        in_ready <= 1'b1;
                        state    <= HALF;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/demux12_stream.sv
// Registered 1-to-2 stream demultiplexer: one in-order skid buffer steered to outa/outb by dest.
// Optional per-output drain counters (cnt_a/cnt_b) are built when DEMUX12_STATS_EN is defined.
module demux12_stream
    import demux12_pkg::*;
#(
    parameter int WIDTH = 32
`ifdef DEMUX12_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    output logic             outa_valid,
    input  logic             outa_ready,
    output logic [WIDTH-1:0] outa,
    output logic             outb_valid,
    input  logic             outb_ready,
    output logic [WIDTH-1:0] outb
`ifdef DEMUX12_STATS_EN
    , output logic [CNT_W-1:0] cnt_a
    , output logic [CNT_W-1:0] cnt_b
`endif
);

    logic             head_valid;
    logic             head_ready;
    logic [WIDTH:0]   head;
    logic             head_dest;
    logic [WIDTH-1:0] head_data;

    demux12_skid #(
        .W (WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({sel, din}),
        .out_valid (head_valid),
        .out_ready (head_ready),
        .out_data  (head)
    );

    assign head_dest = head[WIDTH];
    assign head_data = head[WIDTH-1:0];

    // Only the addressed consumer's ready matters; the other one is ignored.
    assign head_ready = (head_dest == DEST_B) ? outb_ready : outa_ready;

    assign outa_valid = head_valid & (head_dest == DEST_A);
    assign outb_valid = head_valid & (head_dest == DEST_B);
    assign outa       = head_data;
    assign outb       = head_data;

`ifdef DEMUX12_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (outa_valid && outa_ready) cnt_a <= cnt_a + CNT_W'(1);
            if (outb_valid && outb_ready) cnt_b <= cnt_b + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_demux12_stream.sv
// Self-checking bench for demux12_stream: directed scenarios then random traffic vs a FIFO model.
// Builds with or without DEMUX12_STATS_EN; counters are checked only when the macro is defined.
`timescale 1ns/1ps
module tb_demux12_stream;

    localparam int WIDTH = 32;
`ifdef DEMUX12_STATS_EN
    localparam int TB_CNT_W = 4;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] din;
    logic             outa_valid;
    logic             outa_ready;
    logic [WIDTH-1:0] outa;
    logic             outb_valid;
    logic             outb_ready;
    logic [WIDTH-1:0] outb;
`ifdef DEMUX12_STATS_EN
    logic [TB_CNT_W-1:0] cnt_a;
    logic [TB_CNT_W-1:0] cnt_b;
`endif

    int n_chk = 0;
    int n_err = 0;

    // reference model: plain FIFO of {dest,data}, capacity 2
    logic [WIDTH:0] q[$];
    int             drains_a = 0;
    int             drains_b = 0;

    always #5 clk = ~clk;

    demux12_stream #(
        .WIDTH (WIDTH)
`ifdef DEMUX12_STATS_EN
        , .CNT_W (TB_CNT_W)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .din        (din),
        .outa_valid (outa_valid),
        .outa_ready (outa_ready),
        .outa       (outa),
        .outb_valid (outb_valid),
        .outb_ready (outb_ready),
        .outb       (outb)
`ifdef DEMUX12_STATS_EN
        , .cnt_a    (cnt_a)
        , .cnt_b    (cnt_b)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic           exp_va;
        logic           exp_vb;
        logic [WIDTH:0] h;
        exp_va = 1'b0;
        exp_vb = 1'b0;
        h      = '0;
        if (q.size() > 0) begin
            h      = q[0];
            exp_va = ~h[WIDTH];
            exp_vb = h[WIDTH];
        end
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("outa_valid", 64'(outa_valid), 64'(exp_va));
        chk("outb_valid", 64'(outb_valid), 64'(exp_vb));
        if (q.size() > 0) begin
            chk("outa_data", 64'(outa), 64'(h[WIDTH-1:0]));
            chk("outb_data", 64'(outb), 64'(h[WIDTH-1:0]));
        end
`ifdef DEMUX12_STATS_EN
        chk("cnt_a", 64'(cnt_a), 64'(drains_a % (1 << TB_CNT_W)));
        chk("cnt_b", 64'(cnt_b), 64'(drains_b % (1 << TB_CNT_W)));
`endif
    endtask

    // One clock: drive inputs, predict from the model, advance, compare.
    task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] d,
                        input logic ra, input logic rb);
        logic           acc;
        logic           drn;
        logic [WIDTH:0] h;
        in_valid   = v;
        sel        = s;
        din        = d;
        outa_ready = ra;
        outb_ready = rb;
        acc = v && (q.size() < 2);
        drn = 1'b0;
        h   = '0;
        if (q.size() > 0) begin
            h   = q[0];
            drn = h[WIDTH] ? rb : ra;
        end
        @(posedge clk);
        if (drn) begin
            void'(q.pop_front());
            if (h[WIDTH]) drains_b++;
            else          drains_a++;
        end
        if (acc) q.push_back({s, d});
        #1;
        compare_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_outa_valid"}, 64'(outa_valid), 64'd0);
        chk({tag, "_outb_valid"}, 64'(outb_valid), 64'd0);
        chk({tag, "_outa"}, 64'(outa), 64'd0);
        chk({tag, "_outb"}, 64'(outb), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check_reset_outputs(tag);
        q.delete();
        drains_a = 0;
        drains_b = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b1;
        sel        = 1'b0;
        din        = 32'd11;
        outa_ready = 1'b0;
        outb_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        @(negedge clk);
        rst = 1'b0;

        // first edge after release accepts 11 to A, then 22 to B
        step(1'b1, 1'b0, 32'd11, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'd22, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

        // back-to-back alternating
        for (int i = 1; i <= 4; i++)
            step(1'b1, logic'((i - 1) % 2), 32'(i), 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

        // head-of-line: A stalled, B waits behind it
        step(1'b1, 1'b0, 32'd5, 1'b0, 1'b1);
        step(1'b1, 1'b1, 32'd6, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'd99, 1'b0, 1'b1);
        chk("hol_full_in_ready", 64'(in_ready), 64'd0);
        chk("hol_outb_valid", 64'(outb_valid), 64'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("hol_outb_now", 64'(outb), 64'd6);
        chk("hol_in_ready", 64'(in_ready), 64'd1);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

        // reset while FULL discards both entries
        step(1'b1, 1'b0, 32'd7, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'd8, 1'b0, 1'b0);
        do_reset("rst_full");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

`ifdef DEMUX12_STATS_EN
        do_reset("rst_stats");
        for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 32'(100 + i), 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)  step(1'b1, 1'b1, 32'(200 + i), 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("cnt_a_wrap", 64'(cnt_a), 64'd1);
        chk("cnt_b_three", 64'(cnt_b), 64'd3);
`endif

        // random traffic
        for (int i = 0; i < 600; i++)
            step(logic'(($urandom % 4) != 0), logic'($urandom % 2), 32'($urandom),
                 logic'(($urandom % 3) != 0), logic'(($urandom % 3) != 0));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/demux12_stream.md
Name: demux12_stream

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshakes; the sending-side counterpart of the mux21 select path.
- Steers one WIDTH-bit input stream to output A (sel=0) or output B (sel=1).
- Sits between a producer (e.g. load/store or writeback path) and two consumers (e.g. data memory vs. MMIO).
- Has a two-entry skid buffer: full throughput, no combinational ready path from outputs to input, strict in-order delivery across both outputs.

Parameters:
WIDTH, 32, data width of din/outa/outb
CNT_W, 16, width of transfer counters (used only with DEMUX12_STATS_EN)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
sel  input  1  destination of current input beat: 0=A, 1=B; sampled only on accept
in_valid  input  1  producer has a beat on din/sel
in_ready  output  1  block can accept a beat this cycle
din  input  WIDTH  input data
outa_valid  output  1  beat available on outa
outa_ready  input  1  consumer A accepts
outa  output  WIDTH  data to A
outb_valid  output  1  beat available on outb
outb_ready  input  1  consumer B accepts
outb  output  WIDTH  data to B

Behaviour:
- Reset (async assert, synchronous-to-clk release): main and skid entries invalid, stored data and dest cleared to 0.
  - outa_valid=0, outb_valid=0, outa=0, outb=0, in_ready=1.
- Accept: in_valid & in_ready at a rising edge. Drain: (outa_valid & outa_ready) | (outb_valid & outb_ready).
- Occupancy states:
  - EMPTY: nothing stored.
  - HALF: main valid.
  - FULL: main + skid valid.
- Outputs:
  - in_ready = (state != FULL), registered-state only.
  - outa_valid = main valid & dest==0; outb_valid = main valid & dest==1. Never both 1.
  - outa and outb both carry main data; consumers qualify with their valid.
- Transitions:
  - EMPTY + accept -> HALF; main <= {sel,din}.
  - HALF + accept & drain -> HALF; main <= {sel,din}.
  - HALF + accept & !drain -> FULL; skid <= {sel,din}.
  - HALF + drain & !accept -> EMPTY.
  - FULL + drain -> HALF; main <= skid. No accept is possible in FULL.
  - Otherwise hold.
- Latency: a beat accepted at edge N is visible on its outX_valid after edge N (1 cycle). Throughput is 1 beat/cycle while the addressed consumer stays ready.
- Stability: while outX_valid=1 and outX_ready=0, data, dest and valid hold unchanged.
- Ordering: strict FIFO across destinations. A B-beat behind a stalled A-beat waits (head-of-line blocking by design).
- Ready of the non-addressed output is ignored.
- Reset mid-operation discards both entries; no partial beat is emitted.
- No combinational path from outa_ready/outb_ready to in_ready.

Optional Feature:
- Macro DEMUX12_STATS_EN.
- Defined:
  - Adds output ports cnt_a and cnt_b [CNT_W-1:0].
  - Each counts completed drains on its output, increments by 1 per handshake, wraps modulo 2^CNT_W, and resets to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package demux12_pkg:
  - occupancy state enum typedef (EMPTY/HALF/FULL).
  - constants DEST_A=1'b0, DEST_B=1'b1.
- One sub-module: demux12_skid.
  - Generic two-entry skid buffer carrying {dest,data}, with in_valid/in_ready/out_valid/out_ready.
  - The top does only the valid steering, the ready select and the optional counters.

Test Plan:
- Reset with in_valid=1, din=11 -> in_ready=1, both valids 0, outa=outb=0; after release, first edge accepts 11.
- sel=0, din=11, outa_ready=1 -> outa_valid=1, outa=11 one cycle later, outb_valid=0; then sel=1, din=22, outb_ready=1 -> outb_valid=1, outb=22.
- Back-to-back beats 1,2,3,4 alternating sel 0/1, both readies high -> one beat per cycle, delivered in order A:1, B:2, A:3, B:4, in_ready never drops.
- outa_ready=0, push A:5 then B:6 -> FULL, in_ready=0, outb_valid stays 0 (head-of-line); raise outa_ready -> A:5 drains, next cycle outb=6 valid, in_ready=1.
- Assert rst while FULL (A:7, B:8 stored) -> both valids 0 immediately; no beat 7/8 seen after release.
- With DEMUX12_STATS_EN, CNT_W=4: 17 drains on A, 3 on B -> cnt_a=1 (wrap), cnt_b=3.
